// File: rtl/uart_byte_rx.sv
// uart_byte_rx - 8N1 UART receiver feeding the instruction-memory byte path.
//   clk        : system clock, all logic on posedge
//   rst        : synchronous active-high reset
//   rx_serial  : asynchronous UART line, idle high
//   data_out   : last correctly framed byte (LSB received first), held between pulses
//   dval       : 1-cycle pulse, data_out updated this cycle
//   frame_err  : 1-cycle pulse, stop bit sampled low, byte discarded
//   busy       : high whenever the receiver is not idle
module uart_byte_rx #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic [7:0] data_out,
  output logic       dval,
  output logic       frame_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_FULL = cnt_t'(CLKS_PER_BIT - 1);
  localparam cnt_t CNT_HALF = cnt_t'(HALF_BIT - 1);

  // Bit-centre sampling needs a few clocks per bit to be meaningful.
  if (CLKS_PER_BIT < 4) begin : g_bad_rate
    $error("uart_byte_rx: CLKS_PER_BIT must be >= 4");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_out_q, data_out_d;
  logic       dval_q, dval_d;
  logic       frame_err_q, frame_err_d;
  logic       busy_q, busy_d;
  // Cleared by a framing error; set again once the line is seen high, so a
  // held-low (break) line cannot spawn back-to-back spurious frames.
  logic       armed_q, armed_d;
  logic       sync1_q, rx_s_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_out_d  = data_out_q;
    dval_d      = 1'b0;
    frame_err_d = 1'b0;
    armed_d     = armed_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_s_q) armed_d = 1'b1;
        else if (armed_q) state_d = START;
      end
      START: begin
        cnt_d = cnt_q + cnt_t'(1);
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // Still low at mid start bit: genuine start, else a glitch.
          state_d   = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_q + cnt_t'(1);
        if (cnt_q == CNT_FULL) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        cnt_d = cnt_q + cnt_t'(1);
        if (cnt_q == CNT_FULL) begin
          // Return at mid stop bit so a back-to-back start edge is not missed.
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s_q) begin
            data_out_d = shift_q;
            dval_d     = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            armed_d     = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_out_q  <= '0;
      dval_q      <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      armed_q     <= 1'b1;
    end else begin
      sync1_q     <= rx_serial;
      rx_s_q      <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_out_q  <= data_out_d;
      dval_q      <= dval_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      armed_q     <= armed_d;
    end
  end

  assign data_out  = data_out_q;
  assign dval      = dval_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx - directed bench for uart_byte_rx at 10 clocks per bit.
module tb_uart_byte_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_serial = 1'b1;
  logic [7:0] data_out;
  logic       dval, frame_err, busy;

  uart_byte_rx #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000)) dut (
    .clk(clk), .rst(rst), .rx_serial(rx_serial),
    .data_out(data_out), .dval(dval), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int dval_cnt = 0;
  int ferr_cnt = 0;
  logic ever_busy = 1'b0;
  logic [7:0] bytes[$];
  int dv_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (dval) begin
      dval_cnt++;
      bytes.push_back(data_out);
      dv_cyc.push_back(cyc);
    end
    if (frame_err) ferr_cnt++;
    if (busy) ever_busy = 1'b1;
    if (!rst) chk("dval_ferr_excl", {31'd0, dval & frame_err}, 32'd0);
  end

  task automatic clr();
    dval_cnt = 0;
    ferr_cnt = 0;
    ever_busy = 1'b0;
    bytes.delete();
    dv_cyc.delete();
  endtask

  task automatic drive(input logic v, input int n);
    rx_serial = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive(1'b0, 10);
    for (int i = 0; i < 8; i++) drive(b[i], 10);
    drive(stop_bit, 10);
  endtask

  task automatic snap();
    @(negedge clk);
  endtask

  int t0;
  logic [31:0] word;

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    snap();
    chk("rst_data_out", {24'd0, data_out}, 32'd0);
    chk("rst_dval", {31'd0, dval}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b1, 20);

    // 1: single frame 0xA5
    clr();
    t0 = cyc;
    send_byte(8'hA5, 1'b1);
    drive(1'b1, 30);
    snap();
    chk("t1_dval_cnt", dval_cnt, 1);
    chk("t1_byte", (bytes.size() > 0) ? {24'd0, bytes[0]} : 32'hdead, 32'hA5);
    chk("t1_data_out", {24'd0, data_out}, 32'hA5);
    chk("t1_ferr_cnt", ferr_cnt, 0);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    // Start edge -> 2 sync + 5 half bit + 80 data + 10 stop + 1 register.
    chk("t1_latency", (dv_cyc.size() > 0) ? dv_cyc[0] - t0 : -1, 98);

    // 2: back-to-back 0x13,0x37,0x00,0x00
    clr();
    send_byte(8'h13, 1'b1);
    send_byte(8'h37, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    drive(1'b1, 30);
    chk("t2_dval_cnt", dval_cnt, 4);
    if (bytes.size() == 4) begin
      word = {bytes[3], bytes[2], bytes[1], bytes[0]};
      chk("t2_word", word, 32'h0000_3713);
      chk("t2_gap01", dv_cyc[1] - dv_cyc[0], 100);
      chk("t2_gap12", dv_cyc[2] - dv_cyc[1], 100);
      chk("t2_gap23", dv_cyc[3] - dv_cyc[2], 100);
    end else begin
      chk("t2_byte_count", bytes.size(), 4);
    end
    chk("t2_ferr_cnt", ferr_cnt, 0);

    // 3: bad stop bit keeps previous byte
    send_byte(8'hC3, 1'b1);
    drive(1'b1, 20);
    clr();
    send_byte(8'h55, 1'b0);
    drive(1'b1, 30);
    snap();
    chk("t3_ferr_cnt", ferr_cnt, 1);
    chk("t3_dval_cnt", dval_cnt, 0);
    chk("t3_data_hold", {24'd0, data_out}, 32'hC3);
    clr();
    send_byte(8'h0F, 1'b1);
    drive(1'b1, 30);
    snap();
    chk("t3_good_dval", dval_cnt, 1);
    chk("t3_good_data", {24'd0, data_out}, 32'h0F);

    // 4: 3-cycle glitch
    clr();
    drive(1'b0, 3);
    drive(1'b1, 30);
    snap();
    chk("t4_entered_start", {31'd0, ever_busy}, 32'd1);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_dval_cnt", dval_cnt, 0);
    chk("t4_ferr_cnt", ferr_cnt, 0);

    // 5: reset mid-DATA of 0xFF
    clr();
    drive(1'b0, 10);
    drive(1'b1, 35);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    snap();
    chk("t5_data_out", {24'd0, data_out}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_dval", {31'd0, dval}, 32'd0);
    chk("t5_frame_err", {31'd0, frame_err}, 32'd0);
    drive(1'b1, 80);
    chk("t5_no_dval", dval_cnt, 0);
    clr();
    send_byte(8'h81, 1'b1);
    drive(1'b1, 30);
    snap();
    chk("t5_next_dval", dval_cnt, 1);
    chk("t5_next_data", {24'd0, data_out}, 32'h81);

    // 6: break, 30 bit times low
    clr();
    drive(1'b0, 300);
    snap();
    chk("t6_ferr_cnt", ferr_cnt, 1);
    chk("t6_dval_cnt", dval_cnt, 0);
    drive(1'b1, 30);
    chk("t6_ferr_after_high", ferr_cnt, 1);
    clr();
    send_byte(8'h3C, 1'b1);
    drive(1'b1, 30);
    snap();
    chk("t6_next_dval", dval_cnt, 1);
    chk("t6_next_ferr", ferr_cnt, 0);
    chk("t6_next_data", {24'd0, data_out}, 32'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
